// File: rtl/mips_mdu.sv
`default_nettype none
// ============================================================================
// Module      : mips_mdu
// Description : Multiply/divide unit with architectural HI/LO registers.
//               MULT/MULTU/DIV/DIVU compute their result at acceptance,
//               hold it in pending registers, and commit it to HI/LO after
//               a fixed number of busy cycles. MTHI/MTLO write in one cycle.
//               A divide by zero runs the full latency and leaves HI/LO
//               unchanged.
// Revision    : 1.0  initial release
// ============================================================================
module mips_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Operation encoding on md_op; 0 and 7 are no-ops.
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    // Counter must hold the larger of the two latencies.
    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CW-1:0]  c_MULT_LOAD = c_CW'(MULT_CYCLES);
    localparam logic [c_CW-1:0]  c_DIV_LOAD  = c_CW'(DIV_CYCLES);
    localparam logic [c_CW-1:0]  c_CNT_ONE   = c_CW'(1);
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    // Architectural and in-flight state.
    logic             r_busy;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_commit;     // cleared for divide by zero

    // Arithmetic datapath, evaluated on the current operands.
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_b_zero;

    assign w_is_signed = (md_op == c_OP_MULT) || (md_op == c_OP_DIV);
    assign w_a_neg     = w_is_signed & src_a[WIDTH-1];
    assign w_b_neg     = w_is_signed & src_b[WIDTH-1];
    assign w_b_zero    = (src_b == '0);

    // Product: extend both operands to 2*WIDTH, then the low 2*WIDTH bits of
    // the product are exact for both signed and unsigned interpretation.
    assign w_ext_a = {{WIDTH{w_a_neg}}, src_a};
    assign w_ext_b = {{WIDTH{w_b_neg}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Division on magnitudes. The magnitude of MIN is 2^(WIDTH-1) read as
    // unsigned, so MIN / -1 naturally yields quotient MIN and remainder 0.
    // A zero divisor is replaced by one purely to keep the datapath defined;
    // that result is never committed.
    assign w_a_mag  = w_a_neg ? (~src_a + c_ONE) : src_a;
    assign w_b_mag  = w_b_neg ? (~src_b + c_ONE) : src_b;
    assign w_b_safe = w_b_zero ? c_ONE : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;

    // Truncation toward zero: quotient sign is the XOR of operand signs,
    // remainder follows the dividend.
    assign w_quot = (w_a_neg ^ w_b_neg) ? (~w_q_mag + c_ONE) : w_q_mag;
    assign w_rem  = w_a_neg ? (~w_r_mag + c_ONE) : w_r_mag;

    // Accept, count down, and commit HI/LO; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_commit  <= 1'b0;
        end else if (r_busy) begin
            if (r_count == c_CNT_ONE) begin
                r_busy  <= 1'b0;
                r_count <= '0;
                if (r_commit) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_count <= r_count - c_CNT_ONE;
            end
        end else if (start) begin
            case (md_op)
                c_OP_MULT, c_OP_MULTU: begin
                    r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_pend_lo <= w_prod[WIDTH-1:0];
                    r_commit  <= 1'b1;
                    r_count   <= c_MULT_LOAD;
                    r_busy    <= 1'b1;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    r_pend_hi <= w_rem;
                    r_pend_lo <= w_quot;
                    r_commit  <= ~w_b_zero;
                    r_count   <= c_DIV_LOAD;
                    r_busy    <= 1'b1;
                end
                c_OP_MTHI: r_hi <= src_a;
                c_OP_MTLO: r_lo <= src_a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
